// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch FIFO of {pc, inst} pairs between the instruction ROM and the IF stage.
// Optional build macro PREFETCH_BYPASS_EN: an empty queue forwards the ROM word straight to IF.
module inst_prefetch_buffer #(
    parameter int              DEPTH    = 4,
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    rom_ce,
    output logic [AW-1:0]           rom_addr,
    input  logic [DW-1:0]           rom_inst,
    input  logic                    cpu_ready,
    output logic                    inst_valid,
    output logic [DW-1:0]           inst,
    output logic [AW-1:0]           inst_pc,
    input  logic                    redirect,
    input  logic [AW-1:0]           redirect_pc,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic [1:0]              dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [AW-1:0]  r_fetch_pc;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_pc_mem   [DEPTH];
    logic [DW-1:0]  r_inst_mem [DEPTH];

    logic w_has_data;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_bypass;
    logic w_bypass_take;

    // Handshake: an entry transfers to IF on a cycle where inst_valid & cpu_ready are both
    // high at the rising edge; a redirect in the same cycle cancels the transfer.
    assign w_has_data = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = w_has_data & cpu_ready & ~redirect;

`ifdef PREFETCH_BYPASS_EN
    assign w_bypass = ~w_has_data & (r_state == S_RUN) & ~redirect;
`else
    assign w_bypass = 1'b0;
`endif
    // A bypassed word taken by IF is never written into the queue.
    assign w_bypass_take = w_bypass & cpu_ready;
    assign w_push = (r_state == S_RUN) & ~redirect & (~w_full | w_pop) & ~w_bypass_take;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: w_next_state = S_RUN;
            S_RUN: begin
                if (w_push && !w_pop && (r_count == CW'(DEPTH - 1)))
                    w_next_state = S_FULL;
            end
            S_FULL: begin
                if (w_pop || redirect)
                    w_next_state = S_RUN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_next_state;
            if (redirect) begin
                r_fetch_pc <= redirect_pc & ~AW'(3);
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                if (w_push || w_bypass_take)
                    r_fetch_pc <= r_fetch_pc + AW'(4);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
            r_inst_mem[r_wr_ptr] <= rom_inst;
        end
    end

    assign rom_ce     = (r_state == S_RUN);
    assign rom_addr   = r_fetch_pc;
    assign q_count    = r_count;
    assign dbg_state  = r_state;
    assign inst_valid = (w_has_data | w_bypass) & ~redirect;

    always_comb begin
        inst    = '0;
        inst_pc = '0;
        if (w_has_data) begin
            inst    = r_inst_mem[r_rd_ptr];
            inst_pc = r_pc_mem[r_rd_ptr];
        end else if (w_bypass) begin
            inst    = rom_inst;
            inst_pc = r_fetch_pc;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed self-checking bench for inst_prefetch_buffer; honours PREFETCH_BYPASS_EN when defined.
module tb_inst_prefetch_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

`ifdef PREFETCH_BYPASS_EN
    localparam int STREAM_CNT = 0;
`else
    localparam int STREAM_CNT = 1;
`endif

    // Clock and reset
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cpu_ready = 1'b0;
    logic           redirect = 1'b0;
    logic [AW-1:0]  redirect_pc = '0;
    logic           rom_ce;
    logic [AW-1:0]  rom_addr;
    logic [DW-1:0]  rom_inst;
    logic           inst_valid;
    logic [DW-1:0]  inst;
    logic [AW-1:0]  inst_pc;
    logic [2:0]     q_count;
    logic [1:0]     dbg_state;

    always #5 clk = ~clk;

    // ROM: word i holds 32'h1000_0000 + i
    assign rom_inst = 32'h1000_0000 + {2'b00, rom_addr[31:2]};

    inst_prefetch_buffer #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .cpu_ready(cpu_ready), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .q_count(q_count), .dbg_state(dbg_state)
    );

    // Scoreboard
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h1000_0000 + (pc >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        cpu_ready = ready;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_ce",    32'(rom_ce),     32'd0);
        check("rst_count", 32'(q_count),    32'd0);
        check("rst_inst",  inst,            32'd0);
        check("rst_pc",    inst_pc,         32'd0);
        check("rst_state", 32'(dbg_state),  32'd0);
        rst = 1'b1;
        #1;
        check("idle_ce", 32'(rom_ce), 32'd0);
    endtask

    // Without bypass the first entry after a flush/startup is one cycle later.
    task automatic first_wait();
`ifndef PREFETCH_BYPASS_EN
        check("gap_valid", 32'(inst_valid), 32'd0);
        step();
`endif
    endtask

    task automatic startup();
        step();
        check("run_ce",   32'(rom_ce), 32'd1);
        check("run_addr", rom_addr,    32'd0);
        first_wait();
    endtask

    task automatic run_stream(input string tag, input logic [31:0] start_pc, input int n,
                              input int exp_cnt);
        logic [31:0] pc;
        for (int i = 0; i < n; i++)
            exp_q.push_back(start_pc + 32'(4 * i));
        while (exp_q.size() > 0) begin
            pc = exp_q.pop_front();
            check({tag, "_valid"}, 32'(inst_valid), 32'd1);
            check({tag, "_pc"},    inst_pc,         pc);
            check({tag, "_inst"},  inst,            rom_word(pc));
            if (exp_cnt >= 0)
                check({tag, "_count"}, 32'(q_count), 32'(exp_cnt));
            step();
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_pc = pc;
        redirect = 1'b1;
        #1;
        check("redir_mask", 32'(inst_valid), 32'd0);
        step();
        redirect = 1'b0;
        #1;
        check("redir_count", 32'(q_count),   32'd0);
        check("redir_addr",  rom_addr,       pc & 32'hFFFF_FFFC);
        check("redir_state", 32'(dbg_state), 32'd1);
    endtask

    initial begin
        // Reset and startup stream
        do_reset(1'b1);
        startup();
        run_stream("start", 32'h0, 6, STREAM_CNT);

        // Fill and stall, then drain with no bubble
        do_reset(1'b0);
        repeat (5) step();
        check("fill_count", 32'(q_count),   32'd4);
        check("fill_state", 32'(dbg_state), 32'd2);
        check("fill_ce",    32'(rom_ce),    32'd0);
        check("fill_head",  inst_pc,        32'd0);
        repeat (2) step();
        check("stall_count", 32'(q_count), 32'd4);
        check("stall_pc",    inst_pc,      32'd0);
        check("stall_inst",  inst,         32'h1000_0000);
        cpu_ready = 1'b1;
        #1;
        run_stream("drain", 32'h0, 5, -1);

        // Redirect with queue part-full
        do_reset(1'b0);
        repeat (4) step();
        check("part_count", 32'(q_count), 32'd3);
        do_redirect(32'h0000_0043);
`ifdef PREFETCH_BYPASS_EN
        check("part_byp_pc", inst_pc, 32'h40);
`else
        check("part_gap", 32'(inst_valid), 32'd0);
`endif
        step();
        check("part_valid", 32'(inst_valid), 32'd1);
        check("part_pc",    inst_pc,         32'h40);
        check("part_inst",  inst,            32'h1000_0010);
        check("part_cnt",   32'(q_count),    32'd1);

        // Redirect while full with cpu_ready high: no pop that cycle
        do_reset(1'b0);
        repeat (5) step();
        check("full2_count", 32'(q_count), 32'd4);
        cpu_ready = 1'b1;
        do_redirect(32'h0000_0100);
        first_wait();
        run_stream("fullredir", 32'h100, 3, -1);

        // Address wrap
        do_redirect(32'hFFFF_FFF8);
        first_wait();
        run_stream("wrap", 32'hFFFF_FFF8, 3, -1);

        // Async reset mid-run
        do_reset(1'b0);
        repeat (3) step();
        check("mid_count", 32'(q_count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", 32'(inst_valid), 32'd0);
        check("async_ce",    32'(rom_ce),     32'd0);
        check("async_count", 32'(q_count),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_ready = 1'b1;
        startup();
        run_stream("restart", 32'h0, 4, STREAM_CNT);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_buffer.md
Name: inst_prefetch_buffer

Overview:
- Instruction prefetch queue between the instruction ROM and the pipeline CPU's IF stage.
- Fetches sequentially from ROM into a small FIFO of {pc, inst} pairs and hands them to IF under a valid/ready handshake.
- On a taken branch/jump the queue is flushed and fetch resumes at the target.
- Decouples ROM timing from IF stalls so the CPU does not re-fetch on hazard stalls.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 32, instruction address width (matches `InstAddrWidth).
- DW, 32, instruction data width (matches `InstDataWidth).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted); deassertion is synchronised externally.
- rom_ce  out  1  ROM chip enable.
- rom_addr  out  AW  ROM fetch address (byte address, word aligned).
- rom_inst  in  DW  ROM read data; combinational, valid in the same cycle as rom_addr.
- cpu_ready  in  1  IF stage accepts the head entry this cycle.
- inst_valid  out  1  head entry valid.
- inst  out  DW  head instruction.
- inst_pc  out  AW  address of head instruction.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  AW  new fetch address; bits [1:0] ignored (forced 0).
- q_count  out  log2(DEPTH)+1  current occupancy, for debug/perf.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; rd_ptr=wr_ptr=0; count=0; state=IDLE.
  - rom_ce=0, inst_valid=0, inst=0, inst_pc=0, q_count=0.
- FSM states:
  - IDLE: first cycle after reset release; rom_ce=0, no push; always goes to RUN next cycle.
  - RUN: rom_ce=1, rom_addr=fetch_pc; goes to FULL when a push takes count to DEPTH with no pop.
  - FULL: rom_ce=0, no push; goes to RUN on any pop or redirect.
  - Redirect from any non-IDLE state goes to RUN.
- pop = inst_valid & cpu_ready & ~redirect.
- push = (state==RUN) & ~redirect & (count<DEPTH | pop).
  - On push: write {fetch_pc, rom_inst} at wr_ptr; wr_ptr++ (mod DEPTH); fetch_pc += 4 (wraps modulo 2^AW).
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full with pop in RUN: push still allowed in the same cycle.
- Outputs:
  - inst_valid = (count!=0) & ~redirect.
  - inst and inst_pc = head entry when count!=0, else 0.
  - Outputs are combinational from registers; no input-to-output path except the redirect masking.
- Redirect (highest priority):
  - count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[AW-1:2],2'b00}.
  - No push and no pop that cycle.
  - First new entry is pushed the next cycle and is visible 2 cycles after redirect.
- Latency:
  - Empty queue: ROM word sampled in cycle N appears on inst_valid in cycle N+1.
  - Reset release: first inst_valid is 2 cycles after reset release (IDLE, then the first push).
- Back-pressure: cpu_ready=0 holds the head stable (inst and inst_pc unchanged) until accepted or redirected.
- Reset mid-operation: async clear to reset values immediately; contents discarded.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined: when count==0, state==RUN and redirect==0:
  - inst_valid=1, inst=rom_inst, inst_pc=fetch_pc combinationally.
  - If cpu_ready=1, the word is consumed without being written (fetch_pc += 4, count stays 0).
  - If cpu_ready=0, it is pushed normally.
  - Gives zero-cycle latency on an empty queue; first inst_valid is 1 cycle after reset release.
- Not defined: no bypass; latency exactly as above.

Test Plan:
- Reset & startup:
  - ROM word[i]=32'h1000_0000+i, rst low 3 cycles then high, cpu_ready=1.
  - inst_valid first rises 2 cycles after release with inst_pc=0, inst=32'h1000_0000.
  - Thereafter one instruction per cycle, pc 0,4,8,...
- Fill & stall:
  - cpu_ready=0 from release.
  - q_count reaches 4 after 5 cycles; state FULL, rom_ce=0.
  - Head stays pc=0 while stalled; raising cpu_ready then delivers pc 0,4,8,12,16 back-to-back with no bubble.
- Redirect with queue part-full:
  - q_count=3, assert redirect with redirect_pc=32'h0000_0043 for 1 cycle.
  - In that cycle inst_valid=0 and q_count goes to 0.
  - Next fetch rom_addr=32'h40; inst_pc=32'h40 valid 2 cycles after redirect.
- Redirect while full with cpu_ready=1:
  - redirect wins; no pop is recorded (scoreboard sees no pc consumed that cycle).
- Address wrap:
  - redirect_pc=32'hFFFF_FFF8, cpu_ready=1.
  - Delivered pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-run:
  - Drop rst between clock edges with q_count=2.
  - inst_valid, rom_ce and q_count go to 0 immediately without waiting for a clock edge.
  - After release the sequence restarts at RESET_PC.
- PREFETCH_BYPASS_EN build:
  - Rerun the first scenario; first inst_valid is 1 cycle after release, pc=0.
  - q_count stays 0 throughout while cpu_ready=1.
